wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters: ADDRW, default 5, register address width; DATAW, default 32, data width; DEPTH, default 2, load-queue entries (power of two); STARVE, default 4, cycles the queue may stay full before the ALU is throttled.
REQ-002 clk  in  1  single clock; all state is updated on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 alu_valid  in  1  ALU result is present this cycle.
REQ-005 alu_ready  out  1  arbiter accepts the ALU result this cycle.
REQ-006 alu_rd / alu_data  in  ADDRW / DATAW  ALU destination register and ALU value.
REQ-007 ld_valid  in  1  load result is present this cycle.
REQ-008 ld_ready  out  1  load queue can accept a result this cycle.
REQ-009 ld_rd / ld_data  in  ADDRW / DATAW  load destination register and load value.
REQ-010 rf_wr_en / rf_addr_d / rf_data_d  out  1 / ADDRW / DATAW  registered register-file write port.
REQ-011 rd_addr_a / rd_addr_b  in  ADDRW  register-file read addresses, used for the bypass check.
REQ-012 byp_hit_a / byp_hit_b  out  1  bypass valid for read port A / read port B.
REQ-013 byp_data_a / byp_data_b  out  DATAW  bypass value for read port A / read port B.
REQ-014 busy  out  1  load queue is non-empty.

Function
REQ-015 ALU handshake SHALL complete when alu_valid and alu_ready are both 1; load handshake SHALL complete when ld_valid and ld_ready are both 1.
REQ-016 ld_ready SHALL equal "queue not full"; a push while full is impossible by construction.
REQ-017 Each cycle, the write source SHALL be selected as follows: an accepted ALU result has priority; otherwise the queue head is popped if the queue is non-empty; otherwise there is no write.
REQ-018 The selected write SHALL appear on rf_wr_en/rf_addr_d/rf_data_d one cycle later, i.e. 1-cycle latency; rf_wr_en SHALL be 0 in every cycle with no selected write.
REQ-019 Results with rd==0 SHALL complete their handshake normally but SHALL be discarded: the entry is not queued and no write is issued.
REQ-020 Squash rule: when an accepted ALU result has the same rd as a valid queued entry, that queued entry SHALL be invalidated, because the ALU result is younger.
REQ-021 An invalidated entry SHALL still occupy its slot, and popping it SHALL produce rf_wr_en=0.
REQ-022 Simultaneous ALU accept and load push with equal rd: the load SHALL be accepted with ld_ready=1 and then discarded.
REQ-023 Simultaneous push and pop on a full queue SHALL NOT be allowed, because ld_ready=0 when the queue is full.
REQ-024 Simultaneous push and pop on a non-full queue SHALL leave the occupancy unchanged.
REQ-025 Starvation counter: it SHALL increment on each cycle in which the queue is full and no pop occurs, and SHALL clear on any pop.
REQ-026 When the starvation counter reaches STARVE, alu_ready SHALL go 0 for exactly one cycle, forcing a pop; otherwise alu_ready=1.
REQ-027 Queue pointers SHALL wrap modulo DEPTH.
REQ-028 The occupancy count SHALL range 0..DEPTH inclusive.
REQ-029 busy SHALL be 1 exactly when the occupancy is non-zero.

Reset
REQ-030 When rst_n=0, the block SHALL reset asynchronously: queue empty, pointers 0, starvation counter 0.
REQ-031 During reset, rf_wr_en, byp_hit_a/b and busy SHALL be 0; rf_addr_d, rf_data_d and byp_data_a/b SHALL be 0.
REQ-032 After reset, alu_ready SHALL be 1 and ld_ready SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL drop all queued loads silently, and no write SHALL be emitted for them.

Configuration
REQ-034 The bypass feature SHALL be controlled by the macro WB_BYPASS_EN.
REQ-035 With WB_BYPASS_EN defined, byp_hit_x SHALL be 1 when rf_wr_en=1, rd_addr_x==rf_addr_d and rd_addr_x!=0; in that case byp_data_x=rf_data_d.
REQ-036 With WB_BYPASS_EN defined, the bypass SHALL be purely combinational.
REQ-037 Without WB_BYPASS_EN, the bypass ports SHALL still exist, with byp_hit_a/b tied to 0 and byp_data_a/b tied to 0.

Structure
REQ-038 The shared core package SHALL hold ADDRW/DATAW defaults and the x0 index constant.
REQ-039 The shared core package SHALL hold a wb_entry typedef containing valid, rd and data.
REQ-040 The load queue SHALL be a sub-module named wb_fifo: a DEPTH-entry FIFO of wb_entry that supports per-entry invalidation by rd match.

Verification
REQ-041 ALU-only write: alu_valid=1, rd=5, data=0xDEADBEEF -> next cycle rf_wr_en=1, rf_addr_d=5, rf_data_d=0xDEADBEEF.
REQ-042 Load-then-ALU squash: load rd=3, data=0x11 is queued while the ALU streams rd=7; then ALU rd=3, data=0x22 -> only 0x22 is written to x3, and popping the stale entry gives rf_wr_en=0.
REQ-043 Writes to x0: ALU rd=0 and load rd=0 -> no write ever, and busy remains 0.
REQ-044 Starvation: the queue is filled (2 loads) and alu_valid=1 is held continuously -> alu_ready=0 for exactly one cycle after 4 full cycles, and a load write occurs in that slot.
REQ-045 Bypass (WB_BYPASS_EN defined): rd_addr_a=9 in the cycle rf_wr_en=1 with addr 9, data 0x55 -> byp_hit_a=1, byp_data_a=0x55.
REQ-046 Bypass (WB_BYPASS_EN undefined): same stimulus as REQ-045 -> byp_hit_a=0.
REQ-047 Reset mid-operation: rst_n pulled low with 2 loads queued -> outputs 0 immediately, and no writes follow after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core package for the write-back arbiter.
// Holds default widths, the x0 index and the queue entry type.
package wb_arbiter_pkg;

    localparam int ADDRW_DEF = 5;
    localparam int DATAW_DEF = 32;
    localparam int X0        = 0;

    typedef struct packed {
        logic                 valid;
        logic [ADDRW_DEF-1:0] rd;
        logic [DATAW_DEF-1:0] data;
    } wb_entry;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU/load handshakes, RF write port, bypass.
// master = producer/consumer side, slave = the arbiter.
interface wb_arbiter_if #(
    parameter int ADDRW = 5,
    parameter int DATAW = 32
);
    logic             alu_valid;
    logic             alu_ready;
    logic [ADDRW-1:0] alu_rd;
    logic [DATAW-1:0] alu_data;
    logic             ld_valid;
    logic             ld_ready;
    logic [ADDRW-1:0] ld_rd;
    logic [DATAW-1:0] ld_data;
    logic             rf_wr_en;
    logic [ADDRW-1:0] rf_addr_d;
    logic [DATAW-1:0] rf_data_d;
    logic [ADDRW-1:0] rd_addr_a;
    logic [ADDRW-1:0] rd_addr_b;
    logic             byp_hit_a;
    logic             byp_hit_b;
    logic [DATAW-1:0] byp_data_a;
    logic [DATAW-1:0] byp_data_b;
    logic             busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output rd_addr_a, rd_addr_b,
        input  alu_ready, ld_ready,
        input  rf_wr_en, rf_addr_d, rf_data_d,
        input  byp_hit_a, byp_hit_b,
        input  byp_data_a, byp_data_b, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  rd_addr_a, rd_addr_b,
        output alu_ready, ld_ready,
        output rf_wr_en, rf_addr_d, rf_data_d,
        output byp_hit_a, byp_hit_b,
        output byp_data_a, byp_data_b, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// Load queue: DEPTH-entry FIFO of write-back entries with
// per-entry invalidation on rd match. Ports: push/pop, squash, head, flags.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter int  ADDRW   = ADDRW_DEF,
    parameter type entry_t = wb_entry
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    input  logic             sq_en_i,
    input  logic [ADDRW-1:0] sq_rd_i,
    output entry_t           head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wp_q;
    logic [PW-1:0]   rp_q;
    logic [CW-1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            // A younger ALU write kills older queued values of the same rd;
            // the slot stays occupied and pops as a no-write.
            for (int i = 0; i < DEPTH; i++) begin
                if (sq_en_i && mem_q[i].rd == sq_rd_i) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (push_i) begin
                mem_q[wp_q] <= push_data_i;
                wp_q        <= wp_q + PW'(1);
            end
            if (pop_i) begin
                rp_q <= rp_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rp_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win the RF write port, loads queue up.
// Optional combinational bypass enabled by macro WB_BYPASS_EN.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ADDRW  = ADDRW_DEF,
    parameter int DATAW  = DATAW_DEF,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [ADDRW-1:0] rd;
        logic [DATAW-1:0] data;
    } entry_t;

    localparam int SW = $clog2(STARVE + 1);
    localparam logic [ADDRW-1:0] RZ = ADDRW'(X0);

    logic             alu_rdy;
    logic             alu_acc;
    logic             ld_acc;
    logic             pop;
    logic             push;
    logic             sq_en;
    logic             full;
    logic             empty;
    entry_t           head;
    entry_t           push_ent;
    logic [SW-1:0]    starve_q, starve_d;
    logic             wr_en_q, wr_en_d;
    logic [ADDRW-1:0] wr_addr_q, wr_addr_d;
    logic [DATAW-1:0] wr_data_q, wr_data_d;

    always_comb begin
        alu_rdy   = (starve_q != SW'(STARVE));
        alu_acc   = bus.alu_valid && alu_rdy;
        ld_acc    = bus.ld_valid && !full;
        pop       = !alu_acc && !empty;
        sq_en     = alu_acc && (bus.alu_rd != RZ);
        // Same-rd load alongside an ALU write is older: drop it.
        push      = ld_acc && (bus.ld_rd != RZ)
                    && !(alu_acc && bus.alu_rd == bus.ld_rd);
        push_ent  = '{valid: 1'b1, rd: bus.ld_rd, data: bus.ld_data};
        wr_en_d   = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        unique case (1'b1)
            alu_acc: begin
                wr_en_d   = (bus.alu_rd != RZ);
                wr_addr_d = bus.alu_rd;
                wr_data_d = bus.alu_data;
            end
            pop: begin
                wr_en_d   = head.valid;
                wr_addr_d = head.rd;
                wr_data_d = head.data;
            end
            default: ;
        endcase
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (full) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .ADDRW   (ADDRW),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_ent),
        .pop_i       (pop),
        .sq_en_i     (sq_en),
        .sq_rd_i     (bus.alu_rd),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign bus.alu_ready = alu_rdy;
    assign bus.ld_ready  = !full;
    assign bus.busy      = !empty;
    assign bus.rf_wr_en  = wr_en_q;
    assign bus.rf_addr_d = wr_addr_q;
    assign bus.rf_data_d = wr_data_q;

`ifdef WB_BYPASS_EN
    assign bus.byp_hit_a  = wr_en_q && (bus.rd_addr_a == wr_addr_q)
                            && (bus.rd_addr_a != RZ);
    assign bus.byp_hit_b  = wr_en_q && (bus.rd_addr_b == wr_addr_q)
                            && (bus.rd_addr_b != RZ);
    assign bus.byp_data_a = bus.byp_hit_a ? wr_data_q : '0;
    assign bus.byp_data_b = bus.byp_hit_b ? wr_data_q : '0;
`else
    logic unused_rd;
    assign unused_rd      = ^{bus.rd_addr_a, bus.rd_addr_b};
    assign bus.byp_hit_a  = 1'b0;
    assign bus.byp_hit_b  = 1'b0;
    assign bus.byp_data_a = '0;
    assign bus.byp_data_b = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_wb_arbiter;
    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.ADDRW(AW), .DATAW(DW)) bus ();

    wb_arbiter #(
        .ADDRW  (AW),
        .DATAW  (DW),
        .DEPTH  (DEPTH),
        .STARVE (STARVE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          v;
        bit [AW-1:0] rd;
        bit [DW-1:0] d;
    } ent_t;

    ent_t        mq[$];
    int          starve;
    bit          e_en;
    bit [AW-1:0] e_addr;
    bit [DW-1:0] e_data;
    logic        obs_ardy;
    logic        obs_hit_a;
    logic [DW-1:0] obs_byp_a;
    int          vecs;
    int          errs;

    task automatic model_reset();
        mq.delete();
        starve = 0;
        e_en   = 0;
        e_addr = '0;
        e_data = '0;
    endtask

    task automatic cycle(
        input bit          av,
        input bit [AW-1:0] ard,
        input bit [DW-1:0] ad,
        input bit          lv,
        input bit [AW-1:0] lrd,
        input bit [DW-1:0] ld,
        input bit [AW-1:0] ra,
        input bit [AW-1:0] rb
    );
        bit   x_ardy, x_lrdy, x_busy, x_ha, x_hb;
        bit   aacc, lacc, pop;
        int   n;
        ent_t h;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.ld_valid  = lv;
        bus.ld_rd     = lrd;
        bus.ld_data   = ld;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        @(negedge clk);
        n      = mq.size();
        x_ardy = (starve < STARVE);
        x_lrdy = (n < DEPTH);
        x_busy = (n != 0);
`ifdef WB_BYPASS_EN
        x_ha = e_en && ra == e_addr && ra != 0;
        x_hb = e_en && rb == e_addr && rb != 0;
`else
        x_ha = 0;
        x_hb = 0;
`endif
        obs_ardy  = bus.alu_ready;
        obs_hit_a = bus.byp_hit_a;
        obs_byp_a = bus.byp_data_a;
        vecs += 5;
        if (bus.alu_ready !== x_ardy) begin
            errs++;
            $display("FAIL alu_ready: got %b want %b", bus.alu_ready, x_ardy);
        end
        if (bus.ld_ready !== x_lrdy) begin
            errs++;
            $display("FAIL ld_ready: got %b want %b", bus.ld_ready, x_lrdy);
        end
        if (bus.busy !== x_busy) begin
            errs++;
            $display("FAIL busy: got %b want %b", bus.busy, x_busy);
        end
        if (bus.byp_hit_a !== x_ha) begin
            errs++;
            $display("FAIL byp_hit_a: got %b want %b", bus.byp_hit_a, x_ha);
        end
        if (bus.byp_hit_b !== x_hb) begin
            errs++;
            $display("FAIL byp_hit_b: got %b want %b", bus.byp_hit_b, x_hb);
        end
        if (x_ha || !x_ha) begin
            vecs++;
            if (bus.byp_data_a !== (x_ha ? e_data : '0)) begin
                errs++;
                $display("FAIL byp_data_a: got %h want %h",
                         bus.byp_data_a, x_ha ? e_data : '0);
            end
        end
        if (x_hb) begin
            vecs++;
            if (bus.byp_data_b !== e_data) begin
                errs++;
                $display("FAIL byp_data_b: got %h want %h",
                         bus.byp_data_b, e_data);
            end
        end
        aacc = av && x_ardy;
        lacc = lv && x_lrdy;
        pop  = !aacc && n > 0;
        if (aacc) begin
            e_en   = (ard != 0);
            e_addr = ard;
            e_data = ad;
        end else if (pop) begin
            h      = mq.pop_front();
            e_en   = h.v;
            e_addr = h.rd;
            e_data = h.d;
        end else begin
            e_en = 0;
        end
        if (aacc && ard != 0) begin
            foreach (mq[i]) begin
                if (mq[i].rd == ard) mq[i].v = 0;
            end
        end
        if (lacc && lrd != 0 && !(aacc && ard == lrd)) begin
            h.v  = 1;
            h.rd = lrd;
            h.d  = ld;
            mq.push_back(h);
        end
        if (pop) starve = 0;
        else if (n == DEPTH) starve++;
        @(posedge clk);
        #1;
        vecs++;
        if (bus.rf_wr_en !== e_en) begin
            errs++;
            $display("FAIL rf_wr_en: got %b want %b", bus.rf_wr_en, e_en);
        end
        if (e_en) begin
            vecs += 2;
            if (bus.rf_addr_d !== e_addr) begin
                errs++;
                $display("FAIL rf_addr_d: got %0d want %0d",
                         bus.rf_addr_d, e_addr);
            end
            if (bus.rf_data_d !== e_data) begin
                errs++;
                $display("FAIL rf_data_d: got %h want %h",
                         bus.rf_data_d, e_data);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.ld_valid  = 0; bus.ld_rd  = 0; bus.ld_data  = 0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 0;
        #2 rst_n = 1'b0;
        #2;
        vecs += 6;
        if (bus.rf_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_en_busy: got %b%b want 00",
                     bus.rf_wr_en, bus.busy);
        end
        if (bus.rf_addr_d !== '0) begin
            errs++;
            $display("FAIL reset_addr: got %0d want 0", bus.rf_addr_d);
        end
        if (bus.rf_data_d !== '0) begin
            errs++;
            $display("FAIL reset_data: got %h want 0", bus.rf_data_d);
        end
        if (bus.byp_hit_a !== 1'b0 || bus.byp_hit_b !== 1'b0) begin
            errs++;
            $display("FAIL reset_hit: got %b%b want 00",
                     bus.byp_hit_a, bus.byp_hit_b);
        end
        if (bus.byp_data_a !== '0 || bus.byp_data_b !== '0) begin
            errs++;
            $display("FAIL reset_byp: got %h/%h want 0",
                     bus.byp_data_a, bus.byp_data_b);
        end
        if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready: got %b%b want 11",
                     bus.alu_ready, bus.ld_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_only();
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vecs++;
        if (bus.rf_wr_en !== 1'b1 || bus.rf_addr_d !== 5
            || bus.rf_data_d !== 32'hDEADBEEF) begin
            errs++;
            $display("FAIL alu_only: got %b/%0d/%h want 1/5/deadbeef",
                     bus.rf_wr_en, bus.rf_addr_d, bus.rf_data_d);
        end
        idle(1);
    endtask

    task automatic test_squash();
        cycle(1, 7, 32'h70, 1, 3, 32'h11, 0, 0);
        cycle(1, 3, 32'h22, 0, 0, 0, 0, 0);
        vecs++;
        if (bus.rf_addr_d !== 3 || bus.rf_data_d !== 32'h22) begin
            errs++;
            $display("FAIL squash_alu: got %0d/%h want 3/22",
                     bus.rf_addr_d, bus.rf_data_d);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        vecs += 2;
        if (bus.rf_wr_en !== 1'b0) begin
            errs++;
            $display("FAIL squash_stale: got %b want 0", bus.rf_wr_en);
        end
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL squash_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_x0();
        cycle(1, 0, 32'hAA, 1, 0, 32'hBB, 0, 0);
        cycle(0, 0, 0, 1, 0, 32'hCC, 0, 0);
        cycle(1, 0, 32'hDD, 0, 0, 0, 0, 0);
        vecs++;
        if (bus.rf_wr_en !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL x0: got en=%b busy=%b want 0/0",
                     bus.rf_wr_en, bus.busy);
        end
    endtask

    task automatic test_same_rd();
        cycle(1, 6, 32'h66, 1, 6, 32'h99, 0, 0);
        vecs++;
        if (bus.busy !== 1'b0 || bus.rf_data_d !== 32'h66) begin
            errs++;
            $display("FAIL same_rd: got busy=%b data=%h want 0/66",
                     bus.busy, bus.rf_data_d);
        end
        idle(1);
    endtask

    task automatic test_bypass();
        cycle(1, 9, 32'h55, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 9, 4);
        vecs++;
`ifdef WB_BYPASS_EN
        if (obs_hit_a !== 1'b1 || obs_byp_a !== 32'h55) begin
            errs++;
            $display("FAIL bypass: got %b/%h want 1/55", obs_hit_a, obs_byp_a);
        end
`else
        if (obs_hit_a !== 1'b0) begin
            errs++;
            $display("FAIL bypass_off: got %b want 0", obs_hit_a);
        end
`endif
    endtask

    task automatic test_starve();
        int lows;
        int low_at;
        lows   = 0;
        low_at = -1;
        idle(2);
        cycle(1, 7, 32'h1, 1, 3, 32'h33, 0, 0);
        cycle(1, 7, 32'h2, 1, 4, 32'h44, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 7, 32'(i), 0, 0, 0, 0, 0);
            if (obs_ardy === 1'b0) begin
                lows++;
                low_at = i;
                vecs++;
                if (bus.rf_wr_en !== 1'b1 || bus.rf_addr_d !== 3
                    || bus.rf_data_d !== 32'h33) begin
                    errs++;
                    $display("FAIL starve_pop: got %b/%0d/%h want 1/3/33",
                             bus.rf_wr_en, bus.rf_addr_d, bus.rf_data_d);
                end
            end
        end
        vecs++;
        if (lows != 1 || low_at != STARVE) begin
            errs++;
            $display("FAIL starve_count: got lows=%0d at=%0d want 1 at %0d",
                     lows, low_at, STARVE);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  AW'($urandom_range(0, 7)), $urandom(),
                  $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 7)), $urandom(),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
    endtask

    task automatic test_reset_mid();
        int writes;
        writes = 0;
        idle(3);
        cycle(1, 7, 32'h70, 1, 3, 32'h31, 0, 0);
        cycle(1, 7, 32'h71, 1, 4, 32'h41, 0, 0);
        bus.alu_valid = 0;
        bus.ld_valid  = 0;
        bus.rd_addr_a = 7;
        #2 rst_n = 1'b0;
        #1;
        vecs += 2;
        if (bus.busy !== 1'b0 || bus.rf_wr_en !== 1'b0
            || bus.byp_hit_a !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset_flags: got %b%b%b want 000",
                     bus.busy, bus.rf_wr_en, bus.byp_hit_a);
        end
        if (bus.rf_addr_d !== '0 || bus.rf_data_d !== '0) begin
            errs++;
            $display("FAIL mid_reset_bus: got %0d/%h want 0/0",
                     bus.rf_addr_d, bus.rf_data_d);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 3, 4);
            if (bus.rf_wr_en === 1'b1) writes++;
        end
        vecs++;
        if (writes != 0) begin
            errs++;
            $display("FAIL mid_reset_writes: got %0d want 0", writes);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        model_reset();
        test_reset();
        test_alu_only();
        test_squash();
        test_x0();
        test_same_rd();
        test_bypass();
        test_starve();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
